// File: rtl/loop_stride_addr_gen.sv
// Nested-loop address generator: walks up to 2**LOOP_ID_W loop levels and
// emits base + sum(idx*stride) once per accepted cycle.
module loop_stride_addr_gen #(
    parameter int LOOP_ID_W     = 5,
    parameter int LOOP_ITER_W   = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int ADDR_STRIDE_W = ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic                     cfg_loop_iter_v,
    input  logic [LOOP_ITER_W-1:0]   cfg_loop_iter,
    input  logic                     cfg_stride_v,
    input  logic [ADDR_STRIDE_W-1:0] cfg_stride,
    input  logic                     stall,
    output logic [ADDR_WIDTH-1:0]    addr,
    output logic                     addr_valid,
    output logic                     addr_last,
    output logic                     busy,
    output logic                     done
);
    localparam int MAX_LOOPS = 2**LOOP_ID_W;
    localparam int PTR_W     = LOOP_ID_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t state_q, state_d;

    // Program storage; strides are held already resized to the address width.
    logic [LOOP_ITER_W-1:0] iter_cfg_q [MAX_LOOPS];
    logic [LOOP_ITER_W-1:0] iter_cfg_d [MAX_LOOPS];
    logic [ADDR_WIDTH-1:0]  stride_q   [MAX_LOOPS];
    logic [ADDR_WIDTH-1:0]  stride_d   [MAX_LOOPS];
    logic [PTR_W-1:0]       iter_ptr_q, iter_ptr_d;
    logic [PTR_W-1:0]       stride_ptr_q, stride_ptr_d;

    // Snapshot of the pointers at start: level count and number of strides written.
    logic [PTR_W-1:0]       lvl_cnt_q, lvl_cnt_d;
    logic [PTR_W-1:0]       str_cnt_q, str_cnt_d;

    // Walk state; off holds idx*stride per level so the address is a plain sum.
    logic [LOOP_ITER_W-1:0] idx_q [MAX_LOOPS];
    logic [LOOP_ITER_W-1:0] idx_d [MAX_LOOPS];
    logic [ADDR_WIDTH-1:0]  off_q [MAX_LOOPS];
    logic [ADDR_WIDTH-1:0]  off_d [MAX_LOOPS];
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

    logic all_at_cfg;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            iter_cfg_q   <= '{default: '0};
            stride_q     <= '{default: '0};
            iter_ptr_q   <= '0;
            stride_ptr_q <= '0;
            lvl_cnt_q    <= '0;
            str_cnt_q    <= '0;
            idx_q        <= '{default: '0};
            off_q        <= '{default: '0};
            base_q       <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            iter_cfg_q   <= iter_cfg_d;
            stride_q     <= stride_d;
            iter_ptr_q   <= iter_ptr_d;
            stride_ptr_q <= stride_ptr_d;
            lvl_cnt_q    <= lvl_cnt_d;
            str_cnt_q    <= str_cnt_d;
            idx_q        <= idx_d;
            off_q        <= off_d;
            base_q       <= base_d;
            addr_q       <= addr_d;
        end
    end

    // Next state: empty program goes straight to DONE; last accepted address ends the walk.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (iter_ptr_q != '0) ? S_BUSY : S_DONE;
            S_BUSY: if (!stall && all_at_cfg) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Configuration writes, start snapshot, and odometer-style index advance.
    always_comb begin
        logic                  carry;
        logic [ADDR_WIDTH-1:0] stride_eff;
        logic [ADDR_WIDTH-1:0] sum;
        iter_cfg_d   = iter_cfg_q;
        stride_d     = stride_q;
        iter_ptr_d   = iter_ptr_q;
        stride_ptr_d = stride_ptr_q;
        lvl_cnt_d    = lvl_cnt_q;
        str_cnt_d    = str_cnt_q;
        idx_d        = idx_q;
        off_d        = off_q;
        base_d       = base_q;
        addr_d       = addr_q;
        carry        = 1'b1;
        stride_eff   = '0;
        sum          = '0;
        if (state_q == S_IDLE) begin
            if (cfg_loop_iter_v && (iter_ptr_q < PTR_W'(MAX_LOOPS))) begin
                iter_cfg_d[iter_ptr_q[LOOP_ID_W-1:0]] = cfg_loop_iter;
                iter_ptr_d = iter_ptr_q + PTR_W'(1);
            end
            if (cfg_stride_v && (stride_ptr_q < PTR_W'(MAX_LOOPS))) begin
                stride_d[stride_ptr_q[LOOP_ID_W-1:0]] = ADDR_WIDTH'(cfg_stride);
                stride_ptr_d = stride_ptr_q + PTR_W'(1);
            end
            if (start) begin
                lvl_cnt_d    = iter_ptr_q;
                str_cnt_d    = stride_ptr_q;
                iter_ptr_d   = '0;
                stride_ptr_d = '0;
                base_d       = base_addr;
                idx_d        = '{default: '0};
                off_d        = '{default: '0};
                addr_d       = base_addr;
            end
        end else if ((state_q == S_BUSY) && !stall) begin
            // Innermost level is lvl_cnt-1; scan outward while the carry ripples.
            for (int l = MAX_LOOPS - 1; l >= 0; l--) begin
                if ((PTR_W'(l) < lvl_cnt_q) && carry) begin
                    stride_eff = (PTR_W'(l) < str_cnt_q) ? stride_q[l] : '0;
                    if (idx_q[l] == iter_cfg_q[l]) begin
                        idx_d[l] = '0;
                        off_d[l] = '0;
                    end else begin
                        idx_d[l] = idx_q[l] + LOOP_ITER_W'(1);
                        off_d[l] = off_q[l] + stride_eff;
                        carry    = 1'b0;
                    end
                end
            end
            sum = base_q;
            for (int l = 0; l < MAX_LOOPS; l++) begin
                sum = sum + off_d[l];
            end
            addr_d = sum;
        end
    end

    // Final-address detect: every configured level sits at its count.
    always_comb begin
        all_at_cfg = 1'b1;
        for (int l = 0; l < MAX_LOOPS; l++) begin
            if ((PTR_W'(l) < lvl_cnt_q) && (idx_q[l] != iter_cfg_q[l])) all_at_cfg = 1'b0;
        end
    end

    // Outputs decoded from state.
    always_comb begin
        busy       = (state_q == S_BUSY);
        addr_valid = (state_q == S_BUSY);
        done       = (state_q == S_DONE);
        addr       = addr_q;
        addr_last  = (state_q == S_BUSY) && all_at_cfg;
    end
endmodule

// File: tb/tb_loop_stride_addr_gen.sv
module tb_loop_stride_addr_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic        cfg_loop_iter_v;
    logic [15:0] cfg_loop_iter;
    logic        cfg_stride_v;
    logic [7:0]  cfg_stride;
    logic        stall;
    logic [7:0]  addr;
    logic        addr_valid;
    logic        addr_last;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        int               n_iter;
        int               n_str;
        logic [3:0][15:0] iter;
        logic [3:0][7:0]  stride;
        logic [7:0]       base;
        int               n_exp;
        logic [7:0][7:0]  exp_a;
        int               stall_addr;
        int               stall_len;
        int               exp_held;
        logic             busy_start;
    } vec_t;

    vec_t vecs [7];
    logic [7:0] exp_q [$];

    loop_stride_addr_gen dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .cfg_loop_iter_v(cfg_loop_iter_v), .cfg_loop_iter(cfg_loop_iter),
        .cfg_stride_v(cfg_stride_v), .cfg_stride(cfg_stride), .stall(stall),
        .addr(addr), .addr_valid(addr_valid), .addr_last(addr_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic program_levels(input vec_t v);
        for (int i = 0; i < v.n_iter; i++) begin
            cfg_loop_iter_v = 1'b1;
            cfg_loop_iter   = v.iter[i];
            @(negedge clk);
        end
        cfg_loop_iter_v = 1'b0;
        for (int i = 0; i < v.n_str; i++) begin
            cfg_stride_v = 1'b1;
            cfg_stride   = v.stride[i];
            @(negedge clk);
        end
        cfg_stride_v = 1'b0;
    endtask

    task automatic run_walk(input int t);
        vec_t v;
        int   held;
        int   stalls;
        int   cyc;
        bit   got_done;
        logic [7:0] e;
        v = vecs[t];
        program_levels(v);
        for (int i = 0; i < v.n_exp; i++) exp_q.push_back(v.exp_a[i]);
        base_addr = v.base;
        start     = 1'b1;
        @(negedge clk);
        start    = v.busy_start;
        held     = 0;
        stalls   = 0;
        cyc      = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 100) begin
            if (done) begin
                got_done = 1'b1;
                start    = 1'b0;
                check($sformatf("v%0d_leftover", t), exp_q.size(), 0);
                check($sformatf("v%0d_done_valid", t), int'(addr_valid), 0);
                check($sformatf("v%0d_done_busy", t), int'(busy), 0);
            end else if (addr_valid) begin
                check($sformatf("v%0d_busy", t), int'(busy), 1);
                if (int'(addr) == v.stall_addr) held++;
                if (int'(addr) == v.stall_addr && stalls < v.stall_len) begin
                    stall = 1'b1;
                    stalls++;
                end else begin
                    stall = 1'b0;
                    check($sformatf("v%0d_extra_addr", t), int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("v%0d_addr", t), int'(addr), int'(e));
                        check($sformatf("v%0d_last", t), int'(addr_last), int'(exp_q.size() == 0));
                    end
                end
            end else begin
                check($sformatf("v%0d_valid_or_done", t), int'(addr_valid | done), 1);
            end
            @(negedge clk);
            cyc++;
        end
        stall = 1'b0;
        start = 1'b0;
        if (!got_done) check($sformatf("v%0d_done_timeout", t), 0, 1);
        if (v.stall_len > 0) check($sformatf("v%0d_held", t), held, v.exp_held);
        check($sformatf("v%0d_done_pulse", t), int'(done), 0);
        exp_q.delete();
    endtask

    initial begin
        bit saw_done;
        // A: 2 levels {1,2} strides {10,1} base 100
        vecs[0] = '0;
        vecs[0].n_iter = 2; vecs[0].n_str = 2;
        vecs[0].iter = {16'd0, 16'd0, 16'd2, 16'd1};
        vecs[0].stride = {8'd0, 8'd0, 8'd1, 8'd10};
        vecs[0].base = 8'd100; vecs[0].n_exp = 6;
        vecs[0].exp_a = {8'd0, 8'd0, 8'd112, 8'd111, 8'd110, 8'd102, 8'd101, 8'd100};
        vecs[0].stall_addr = -1;
        // A with 3 stall cycles on 101
        vecs[1] = vecs[0];
        vecs[1].stall_addr = 101; vecs[1].stall_len = 3; vecs[1].exp_held = 4;
        // B: single level, single address
        vecs[2] = '0;
        vecs[2].n_iter = 1; vecs[2].n_str = 1;
        vecs[2].iter = {16'd0, 16'd0, 16'd0, 16'd0};
        vecs[2].stride = {8'd0, 8'd0, 8'd0, 8'd5};
        vecs[2].base = 8'd7; vecs[2].n_exp = 1;
        vecs[2].exp_a = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7};
        vecs[2].stall_addr = -1;
        // C: nothing programmed since last start
        vecs[3] = '0;
        vecs[3].base = 8'd55; vecs[3].stall_addr = -1;
        // D: wraparound modulo 256
        vecs[4] = '0;
        vecs[4].n_iter = 1; vecs[4].n_str = 1;
        vecs[4].iter = {16'd0, 16'd0, 16'd0, 16'd3};
        vecs[4].stride = {8'd0, 8'd0, 8'd0, 8'd3};
        vecs[4].base = 8'd250; vecs[4].n_exp = 4;
        vecs[4].exp_a = {8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd253, 8'd250};
        vecs[4].stall_addr = -1;
        // E: 3 levels, start held high while busy
        vecs[5] = '0;
        vecs[5].n_iter = 3; vecs[5].n_str = 3;
        vecs[5].iter = {16'd0, 16'd1, 16'd1, 16'd1};
        vecs[5].stride = {8'd0, 8'd1, 8'd50, 8'd100};
        vecs[5].base = 8'd0; vecs[5].n_exp = 8;
        vecs[5].exp_a = {8'd151, 8'd150, 8'd101, 8'd100, 8'd51, 8'd50, 8'd1, 8'd0};
        vecs[5].stall_addr = -1; vecs[5].busy_start = 1'b1;
        // F: inner level has no stride written -> stride 0 (old 50 must not leak)
        vecs[6] = '0;
        vecs[6].n_iter = 2; vecs[6].n_str = 1;
        vecs[6].iter = {16'd0, 16'd0, 16'd1, 16'd1};
        vecs[6].stride = {8'd0, 8'd0, 8'd0, 8'd4};
        vecs[6].base = 8'd20; vecs[6].n_exp = 4;
        vecs[6].exp_a = {8'd0, 8'd0, 8'd0, 8'd0, 8'd24, 8'd24, 8'd20, 8'd20};
        vecs[6].stall_addr = -1;

        reset = 1'b1; start = 1'b0; base_addr = '0; stall = 1'b0;
        cfg_loop_iter_v = 1'b0; cfg_loop_iter = '0; cfg_stride_v = 1'b0; cfg_stride = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_addr", int'(addr), 0);
        check("rst_valid", int'(addr_valid), 0);
        check("rst_last", int'(addr_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        for (int t = 0; t < 7; t++) run_walk(t);

        // Reset during the third address of program A
        program_levels(vecs[0]);
        base_addr = 8'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (addr_valid && addr == 8'd102) break;
            @(negedge clk);
        end
        check("mid_third_addr", int'(addr), 102);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_addr", int'(addr), 0);
        check("mid_rst_valid", int'(addr_valid), 0);
        check("mid_rst_last", int'(addr_last), 0);
        check("mid_rst_busy", int'(busy), 0);
        saw_done = done;
        repeat (3) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        check("mid_rst_no_done", int'(saw_done), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_done", int'(done), 1);
        check("post_rst_valid", int'(addr_valid), 0);
        @(negedge clk);
        check("post_rst_done_end", int'(done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
